// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I multi-cycle control path: opcodes, FSM states,
// write-back selects, instruction classes and the control-output bundle.
package riscv_pkg;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXECUTE,
      ST_MEM_RD,
      ST_MEM_WR,
      ST_WRITEBACK,
      ST_FAULT
   } ctrl_state_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'b00,
      WB_MEM = 2'b01,
      WB_PC4 = 2'b10
   } wb_sel_e;

   typedef enum logic [3:0] {
      CLS_R,
      CLS_I,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_JAL,
      CLS_JALR,
      CLS_LUI,
      CLS_AUIPC,
      CLS_ILLEGAL
   } instr_class_e;

   typedef struct packed {
      logic    imem_req;
      logic    ir_write;
      logic    pc_write;
      logic    pc_src;
      logic    mux_jalr;
      logic    alu_src_imm;
      wb_sel_e wb_sel;
      logic    reg_write;
      logic    dmem_rd;
      logic    dmem_wr;
      logic    instr_done;
      logic    fault;
      logic    fault_cause;
   } ctrl_out_t;

   function automatic instr_class_e classify(input logic [6:0] opc);
      case (opc)
         OPC_R:      return CLS_R;
         OPC_I:      return CLS_I;
         OPC_LOAD:   return CLS_LOAD;
         OPC_STORE:  return CLS_STORE;
         OPC_BRANCH: return CLS_BRANCH;
         OPC_JAL:    return CLS_JAL;
         OPC_JALR:   return CLS_JALR;
         OPC_LUI:    return CLS_LUI;
         OPC_AUIPC:  return CLS_AUIPC;
         default:    return CLS_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/wait_timer.sv
// Memory-wait cycle counter: cleared on entry to a wait state, advanced on each
// cycle without ready, and flags expiry at MEM_TIMEOUT-1 (saturating there).
module wait_timer #(
   parameter int MEM_TIMEOUT = 16,
   parameter int TMR_W       = $clog2(MEM_TIMEOUT) + 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   logic [TMR_W-1:0] count_q;

   assign expired_o = (count_q == TMR_W'(MEM_TIMEOUT - 1));

   // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         count_q <= '0;
      end else if (en_i && !expired_o) begin
         count_q <= count_q + TMR_W'(1);
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with ready
// handshakes to both memories and a sticky FAULT on illegal opcode or timeout.
module multicycle_ctrl
   import riscv_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int TMR_W       = $clog2(MEM_TIMEOUT) + 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       branch_taken,
   input  logic       imem_ready,
   input  logic       dmem_ready,
   output logic       imem_req,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_src,
   output logic       mux_jalr,
   output logic       alu_src_imm,
   output logic [1:0] wb_sel,
   output logic       reg_write,
   output logic       dmem_rd,
   output logic       dmem_wr,
   output logic       instr_done,
   output logic       fault,
   output logic       fault_cause
);

   ctrl_state_e  state_q, state_d;
   instr_class_e class_q, class_d;
   logic         fault_q, fault_d;
   logic         cause_q, cause_d;
   logic         tmr_clr, tmr_en, tmr_expired;
   ctrl_out_t    out_c, out_g;

   wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .TMR_W       (TMR_W)
   ) u_wait_timer (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (tmr_clr),
      .en_i      (tmr_en),
      .expired_o (tmr_expired)
   );

   assign tmr_clr = (state_d != state_q);

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d           = state_q;
      class_d           = class_q;
      fault_d           = fault_q;
      cause_d           = cause_q;
      tmr_en            = 1'b0;
      out_c             = '0;
      out_c.fault       = fault_q;
      out_c.fault_cause = cause_q;

      case (state_q)
         ST_FETCH: begin
            out_c.imem_req = 1'b1;
            tmr_en         = !imem_ready;
            if (imem_ready) begin
               out_c.ir_write = 1'b1;
               state_d        = ST_DECODE;
            end else if (tmr_expired) begin
               state_d = ST_FAULT;
               fault_d = 1'b1;
               cause_d = 1'b1;
            end
         end

         ST_DECODE: begin
            class_d = classify(opcode);
            if (class_d == CLS_ILLEGAL) begin
               state_d = ST_FAULT;
               fault_d = 1'b1;
               cause_d = 1'b0;
            end else begin
               state_d = ST_EXECUTE;
            end
         end

         ST_EXECUTE: begin
            out_c.alu_src_imm = (class_q != CLS_R) && (class_q != CLS_BRANCH);
            out_c.mux_jalr    = (class_q == CLS_JALR);
            case (class_q)
               CLS_LOAD:  state_d = ST_MEM_RD;
               CLS_STORE: state_d = ST_MEM_WR;
               CLS_BRANCH: begin
                  out_c.pc_write   = 1'b1;
                  out_c.pc_src     = branch_taken;
                  out_c.instr_done = 1'b1;
                  state_d          = ST_FETCH;
               end
               default:   state_d = ST_WRITEBACK;
            endcase
         end

         ST_MEM_RD: begin
            out_c.dmem_rd = 1'b1;
            tmr_en        = !dmem_ready;
            if (dmem_ready) begin
               state_d = ST_WRITEBACK;
            end else if (tmr_expired) begin
               state_d = ST_FAULT;
               fault_d = 1'b1;
               cause_d = 1'b1;
            end
         end

         ST_MEM_WR: begin
            out_c.dmem_wr = 1'b1;
            tmr_en        = !dmem_ready;
            if (dmem_ready) begin
               out_c.pc_write   = 1'b1;
               out_c.instr_done = 1'b1;
               state_d          = ST_FETCH;
            end else if (tmr_expired) begin
               state_d = ST_FAULT;
               fault_d = 1'b1;
               cause_d = 1'b1;
            end
         end

         ST_WRITEBACK: begin
            out_c.reg_write  = 1'b1;
            out_c.pc_write   = 1'b1;
            out_c.instr_done = 1'b1;
            out_c.mux_jalr   = (class_q == CLS_JALR);
            case (class_q)
               CLS_JAL, CLS_JALR: begin
                  out_c.wb_sel = WB_PC4;
                  out_c.pc_src = 1'b1;
               end
               CLS_LOAD: out_c.wb_sel = WB_MEM;
               default:  out_c.wb_sel = WB_ALU;
            endcase
            state_d = ST_FETCH;
         end

         ST_FAULT: state_d = ST_FAULT;

         default: state_d = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_FETCH;
         class_q <= CLS_ILLEGAL;
         fault_q <= 1'b0;
         cause_q <= 1'b0;
      end else begin
         state_q <= state_d;
         class_q <= class_d;
         fault_q <= fault_d;
         cause_q <= cause_d;
      end
   end

   // Reset is synchronous, but strobes must drop in the very cycle rst rises.
   assign out_g = rst ? '0 : out_c;

   assign imem_req    = out_g.imem_req;
   assign ir_write    = out_g.ir_write;
   assign pc_write    = out_g.pc_write;
   assign pc_src      = out_g.pc_src;
   assign mux_jalr    = out_g.mux_jalr;
   assign alu_src_imm = out_g.alu_src_imm;
   assign wb_sel      = out_g.wb_sel;
   assign reg_write   = out_g.reg_write;
   assign dmem_rd     = out_g.dmem_rd;
   assign dmem_wr     = out_g.dmem_wr;
   assign instr_done  = out_g.instr_done;
   assign fault       = out_g.fault;
   assign fault_cause = out_g.fault_cause;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle vector table plus directed
// sequences for timeout, ready-at-expiry and reset during a data request.
module tb_multicycle_ctrl;

   // Output vector order: {imem_req,ir_write}_{pc_write,pc_src}_{mux_jalr,alu_src_imm}
   //                      _{wb_sel}_{reg_write,dmem_rd,dmem_wr,instr_done}_{fault,fault_cause}
   localparam logic [13:0] O_IDLE     = 14'b00_00_00_00_0000_00;
   localparam logic [13:0] O_FREQ     = 14'b10_00_00_00_0000_00;
   localparam logic [13:0] O_FACK     = 14'b11_00_00_00_0000_00;
   localparam logic [13:0] O_EX_IMM   = 14'b00_00_01_00_0000_00;
   localparam logic [13:0] O_EX_JALR  = 14'b00_00_11_00_0000_00;
   localparam logic [13:0] O_BR_T     = 14'b00_11_00_00_0001_00;
   localparam logic [13:0] O_BR_N     = 14'b00_10_00_00_0001_00;
   localparam logic [13:0] O_MRD      = 14'b00_00_00_00_0100_00;
   localparam logic [13:0] O_MWR      = 14'b00_00_00_00_0010_00;
   localparam logic [13:0] O_MWR_ACK  = 14'b00_10_00_00_0011_00;
   localparam logic [13:0] O_WB_ALU   = 14'b00_10_00_00_1001_00;
   localparam logic [13:0] O_WB_MEM   = 14'b00_10_00_01_1001_00;
   localparam logic [13:0] O_WB_JAL   = 14'b00_11_00_10_1001_00;
   localparam logic [13:0] O_WB_JALR  = 14'b00_11_10_10_1001_00;
   localparam logic [13:0] O_FLT_ILL  = 14'b00_00_00_00_0000_10;
   localparam logic [13:0] O_FLT_TMO  = 14'b00_00_00_00_0000_11;

   localparam logic [6:0] OP_ADD   = 7'b0110011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   logic       clk;
   logic       rst;
   logic [6:0] opcode;
   logic       branch_taken;
   logic       imem_ready;
   logic       dmem_ready;
   logic       imem_req, ir_write, pc_write, pc_src, mux_jalr, alu_src_imm;
   logic [1:0] wb_sel;
   logic       reg_write, dmem_rd, dmem_wr, instr_done, fault, fault_cause;

   int n_checks = 0;
   int n_fails  = 0;

   typedef struct {
      logic        rst;
      logic [6:0]  opc;
      logic        bt;
      logic        ir;
      logic        dr;
      logic [13:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[$];

   multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .opcode       (opcode),
      .branch_taken (branch_taken),
      .imem_ready   (imem_ready),
      .dmem_ready   (dmem_ready),
      .imem_req     (imem_req),
      .ir_write     (ir_write),
      .pc_write     (pc_write),
      .pc_src       (pc_src),
      .mux_jalr     (mux_jalr),
      .alu_src_imm  (alu_src_imm),
      .wb_sel       (wb_sel),
      .reg_write    (reg_write),
      .dmem_rd      (dmem_rd),
      .dmem_wr      (dmem_wr),
      .instr_done   (instr_done),
      .fault        (fault),
      .fault_cause  (fault_cause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [13:0] outs();
      return {imem_req, ir_write, pc_write, pc_src, mux_jalr, alu_src_imm, wb_sel,
              reg_write, dmem_rd, dmem_wr, instr_done, fault, fault_cause};
   endfunction

   task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [6:0] opc, input logic bt, input logic ir,
                      input logic dr, input logic [13:0] exp, input string name);
      vec_t v;
      v.rst = r; v.opc = opc; v.bt = bt; v.ir = ir; v.dr = dr; v.exp = exp; v.name = name;
      vecs.push_back(v);
   endtask

   // Inputs are already driven; compare at the falling edge, then advance past the next rising edge.
   task automatic cyc(input logic [13:0] exp, input string name);
      @(negedge clk);
      check(name, outs(), exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; opcode = '0; branch_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;

      //   rst   opcode    bt    ir    dr    expected    name
      add(1'b1, OP_ADD,   1'b0, 1'b1, 1'b0, O_IDLE,     "reset_outputs_zero");
      add(1'b0, OP_ADD,   1'b0, 1'b1, 1'b0, O_FACK,     "add_fetch");
      add(1'b0, OP_ADD,   1'b0, 1'b0, 1'b0, O_IDLE,     "add_decode");
      add(1'b0, OP_ADD,   1'b0, 1'b0, 1'b0, O_IDLE,     "add_execute");
      add(1'b0, OP_ADD,   1'b0, 1'b0, 1'b0, O_WB_ALU,   "add_writeback");
      add(1'b0, OP_LOAD,  1'b0, 1'b1, 1'b0, O_FACK,     "load_fetch");
      add(1'b0, OP_LOAD,  1'b0, 1'b0, 1'b0, O_IDLE,     "load_decode");
      add(1'b0, OP_LOAD,  1'b0, 1'b0, 1'b0, O_EX_IMM,   "load_execute");
      add(1'b0, OP_LOAD,  1'b0, 1'b0, 1'b0, O_MRD,      "load_memrd_wait1");
      add(1'b0, OP_LOAD,  1'b0, 1'b0, 1'b0, O_MRD,      "load_memrd_wait2");
      add(1'b0, OP_LOAD,  1'b0, 1'b0, 1'b1, O_MRD,      "load_memrd_ready");
      add(1'b0, OP_LOAD,  1'b0, 1'b0, 1'b0, O_WB_MEM,   "load_writeback");
      add(1'b0, OP_BR,    1'b0, 1'b1, 1'b0, O_FACK,     "brt_fetch");
      add(1'b0, OP_BR,    1'b0, 1'b0, 1'b0, O_IDLE,     "brt_decode");
      add(1'b0, OP_BR,    1'b1, 1'b0, 1'b0, O_BR_T,     "brt_execute");
      add(1'b0, OP_BR,    1'b0, 1'b1, 1'b0, O_FACK,     "brn_fetch");
      add(1'b0, OP_BR,    1'b0, 1'b0, 1'b0, O_IDLE,     "brn_decode");
      add(1'b0, OP_BR,    1'b0, 1'b0, 1'b0, O_BR_N,     "brn_execute");
      add(1'b0, OP_JALR,  1'b0, 1'b0, 1'b0, O_FREQ,     "jalr_fetch_wait");
      add(1'b0, OP_JALR,  1'b0, 1'b1, 1'b0, O_FACK,     "jalr_fetch");
      add(1'b0, OP_JALR,  1'b0, 1'b0, 1'b0, O_IDLE,     "jalr_decode");
      add(1'b0, OP_JALR,  1'b0, 1'b0, 1'b0, O_EX_JALR,  "jalr_execute");
      add(1'b0, OP_JALR,  1'b0, 1'b0, 1'b0, O_WB_JALR,  "jalr_writeback");
      add(1'b0, OP_STORE, 1'b0, 1'b1, 1'b0, O_FACK,     "store_fetch");
      add(1'b0, OP_STORE, 1'b0, 1'b0, 1'b0, O_IDLE,     "store_decode");
      add(1'b0, OP_STORE, 1'b0, 1'b0, 1'b0, O_EX_IMM,   "store_execute");
      add(1'b0, OP_STORE, 1'b0, 1'b0, 1'b1, O_MWR_ACK,  "store_memwr_ready");
      add(1'b0, OP_JAL,   1'b0, 1'b1, 1'b0, O_FACK,     "jal_fetch");
      add(1'b0, OP_JAL,   1'b0, 1'b0, 1'b0, O_IDLE,     "jal_decode");
      add(1'b0, OP_JAL,   1'b0, 1'b0, 1'b0, O_EX_IMM,   "jal_execute");
      add(1'b0, OP_JAL,   1'b0, 1'b0, 1'b0, O_WB_JAL,   "jal_writeback");
      add(1'b0, OP_LUI,   1'b0, 1'b1, 1'b0, O_FACK,     "lui_fetch");
      add(1'b0, OP_LUI,   1'b0, 1'b0, 1'b0, O_IDLE,     "lui_decode");
      add(1'b0, OP_LUI,   1'b0, 1'b0, 1'b0, O_EX_IMM,   "lui_execute");
      add(1'b0, OP_LUI,   1'b0, 1'b0, 1'b0, O_WB_ALU,   "lui_writeback");
      add(1'b0, 7'h00,    1'b0, 1'b1, 1'b0, O_FACK,     "ill_fetch");
      add(1'b0, 7'h00,    1'b0, 1'b0, 1'b0, O_IDLE,     "ill_decode");
      add(1'b0, 7'h00,    1'b0, 1'b0, 1'b0, O_FLT_ILL,  "ill_fault");
      add(1'b0, 7'h00,    1'b0, 1'b1, 1'b1, O_FLT_ILL,  "ill_fault_sticky");
      add(1'b1, 7'h00,    1'b0, 1'b1, 1'b1, O_IDLE,     "ill_reset");

      @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         rst          = vecs[i].rst;
         opcode       = vecs[i].opc;
         branch_taken = vecs[i].bt;
         imem_ready   = vecs[i].ir;
         dmem_ready   = vecs[i].dr;
         cyc(vecs[i].exp, $sformatf("row%0d_%s", i, vecs[i].name));
      end

      // Store never acknowledged: 16 waiting cycles, then sticky timeout fault.
      rst = 1'b0; opcode = OP_STORE; imem_ready = 1'b1; dmem_ready = 1'b0;
      cyc(O_FACK, "tmo_fetch");
      imem_ready = 1'b0;
      cyc(O_IDLE, "tmo_decode");
      cyc(O_EX_IMM, "tmo_execute");
      for (int k = 1; k <= 16; k++) cyc(O_MWR, $sformatf("tmo_wait%0d", k));
      cyc(O_FLT_TMO, "tmo_fault");
      imem_ready = 1'b1; dmem_ready = 1'b1;
      for (int k = 0; k < 3; k++) cyc(O_FLT_TMO, $sformatf("tmo_sticky%0d", k));
      rst = 1'b1;
      cyc(O_IDLE, "tmo_reset");

      // Ready in the 16th waiting cycle beats the expiry.
      rst = 1'b0; dmem_ready = 1'b0;
      cyc(O_FACK, "race_fetch");
      imem_ready = 1'b0;
      cyc(O_IDLE, "race_decode");
      cyc(O_EX_IMM, "race_execute");
      for (int k = 1; k <= 15; k++) cyc(O_MWR, $sformatf("race_wait%0d", k));
      dmem_ready = 1'b1;
      cyc(O_MWR_ACK, "race_ready_at_expiry");
      dmem_ready = 1'b0;
      cyc(O_FREQ, "race_next_fetch_no_fault");

      // Reset raised during MEM_RD drops the strobe in that same cycle.
      opcode = OP_LOAD; imem_ready = 1'b1;
      cyc(O_FACK, "rstrd_fetch");
      imem_ready = 1'b0;
      cyc(O_IDLE, "rstrd_decode");
      cyc(O_EX_IMM, "rstrd_execute");
      cyc(O_MRD, "rstrd_memrd");
      rst = 1'b1;
      cyc(O_IDLE, "rstrd_reset_drops_dmem_rd");
      rst = 1'b0;
      cyc(O_FREQ, "rstrd_fetch_after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
